// File: rtl/sram_mailbox_master.sv
// Mailbox master on the on-chip SRAM port: polls an HPS command word, streams its payload
// over valid/ready, then writes status and clears the command. Optional MBOX_TIMEOUT_EN aborts stalled beats.
module sram_mailbox_master #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned CMD_ADDR     = 0,
    parameter int unsigned STATUS_ADDR  = 1,
    parameter int unsigned PAYLOAD_BASE = 2,
    parameter int unsigned MAX_LEN      = 256,
    parameter int unsigned POLL_GAP     = 16,
    parameter int unsigned TIMEOUT      = 65535
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [8:0]  sram_address,
    output logic        sram_clken,
    output logic        sram_chipselect,
    output logic        sram_write,
    input  logic [31:0] sram_readdata,
    output logic [31:0] sram_writedata,
    output logic [3:0]  sram_byteenable,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [6:0]  out_opcode,
    output logic        out_last,
    output logic        busy,
    output logic [15:0] cmd_count
);

    localparam int unsigned AW  = 9;
    localparam int unsigned DW  = 32;
    localparam int unsigned LW  = 9;
    localparam int unsigned OPW = 7;
    localparam int unsigned CW  = 16;
    localparam int unsigned WW  = 2;
    localparam int unsigned GW  = (POLL_GAP < 1) ? 1 : $clog2(POLL_GAP + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_POLL_RD, S_POLL_WAIT, S_GAP, S_PAY_RD,
        S_PAY_WAIT, S_PUSH, S_STAT_WR, S_CLR_WR
    } state_e;

    state_e         state_q, state_d;
    logic [WW-1:0]  wait_q, wait_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [OPW-1:0] opcode_q, opcode_d;
    logic [LW-1:0]  len_q, len_d;
    logic [LW-1:0]  idx_q, idx_d;
    logic           err_q, err_d;
    logic           out_valid_q, out_valid_d;
    logic [DW-1:0]  out_data_q, out_data_d;
    logic           out_last_q, out_last_d;
    logic           busy_q, busy_d;
    logic [CW-1:0]  cmd_count_q, cmd_count_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           cs_q, cs_d;
    logic           we_q, we_d;
    logic [DW-1:0]  wdata_q, wdata_d;
    logic           rd_done_c;
    logic           stall_hit_c;

`ifdef MBOX_TIMEOUT_EN
    localparam int unsigned SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall_q, stall_d;

    // Consecutive refused cycles of the current beat
    always_comb begin
        stall_d = '0;
        if (state_q == S_PUSH && !out_ready) stall_d = stall_q + SW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stall_q <= '0;
        else          stall_q <= stall_d;
    end

    assign stall_hit_c = (state_q == S_PUSH) && !out_ready && (stall_q == SW'(TIMEOUT - 1));
`else
    assign stall_hit_c = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        wait_d      = '0;
        gap_d       = '0;
        opcode_d    = opcode_q;
        len_d       = len_q;
        idx_d       = idx_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        cmd_count_d = cmd_count_q;
        rd_done_c   = (wait_q == WW'(READ_LATENCY - 1));

        unique case (state_q)
            S_IDLE:      if (enable) state_d = S_POLL_RD;
            S_POLL_RD:   state_d = S_POLL_WAIT;
            S_POLL_WAIT: begin
                if (!rd_done_c) begin
                    wait_d = wait_q + WW'(1);
                end else if (!sram_readdata[31]) begin
                    state_d = S_GAP;
                end else begin
                    opcode_d = sram_readdata[30:24];
                    len_d    = sram_readdata[8:0];
                    idx_d    = '0;
                    err_d    = 1'b0;
                    if (32'(sram_readdata[8:0]) > MAX_LEN) begin
                        err_d   = 1'b1;
                        state_d = S_STAT_WR;
                    end else if (sram_readdata[8:0] == '0) begin
                        state_d = S_STAT_WR;
                    end else begin
                        state_d = S_PAY_RD;
                    end
                end
            end
            S_PAY_RD:    state_d = S_PAY_WAIT;
            S_PAY_WAIT: begin
                if (!rd_done_c) begin
                    wait_d = wait_q + WW'(1);
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = sram_readdata;
                    out_last_d  = (idx_q == LW'(len_q - LW'(1)));
                    state_d     = S_PUSH;
                end
            end
            S_PUSH: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    idx_d       = idx_q + LW'(1);
                    state_d     = out_last_q ? S_STAT_WR : S_PAY_RD;
                end else if (stall_hit_c) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    err_d       = 1'b1;
                    state_d     = S_STAT_WR;
                end
            end
            S_STAT_WR:   state_d = S_CLR_WR;
            S_CLR_WR: begin
                cmd_count_d = cmd_count_q + CW'(1);
                state_d     = S_GAP;
            end
            S_GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GW'(POLL_GAP)) begin
                    gap_d   = '0;
                    state_d = enable ? S_POLL_RD : S_IDLE;
                end
            end
            default:     state_d = S_IDLE;
        endcase

        // SRAM strobes and busy are registered images of the state being entered
        busy_d  = state_d inside {S_PAY_RD, S_PAY_WAIT, S_PUSH, S_STAT_WR, S_CLR_WR};
        cs_d    = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        unique case (state_d)
            S_POLL_RD: begin
                cs_d   = 1'b1;
                addr_d = AW'(CMD_ADDR);
            end
            S_PAY_RD: begin
                cs_d   = 1'b1;
                addr_d = AW'(PAYLOAD_BASE) + idx_d;
            end
            S_STAT_WR: begin
                cs_d    = 1'b1;
                we_d    = 1'b1;
                addr_d  = AW'(STATUS_ADDR);
                wdata_d = {1'b1, err_d, opcode_d, 14'b0, idx_d};
            end
            S_CLR_WR: begin
                cs_d   = 1'b1;
                we_d   = 1'b1;
                addr_d = AW'(CMD_ADDR);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            gap_q       <= '0;
            opcode_q    <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            cmd_count_q <= '0;
            addr_q      <= '0;
            cs_q        <= 1'b0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            gap_q       <= gap_d;
            opcode_q    <= opcode_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            cmd_count_q <= cmd_count_d;
            addr_q      <= addr_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
        end
    end

    assign sram_address    = addr_q;
    assign sram_clken      = cs_q;
    assign sram_chipselect = cs_q;
    assign sram_write      = we_q;
    assign sram_writedata  = wdata_q;
    assign sram_byteenable = {4{cs_q}};
    assign out_valid       = out_valid_q;
    assign out_data        = out_data_q;
    assign out_opcode      = opcode_q;
    assign out_last        = out_last_q;
    assign busy            = busy_q;
    assign cmd_count       = cmd_count_q;

endmodule

// File: tb/tb_sram_mailbox_master.sv
// Directed bench for sram_mailbox_master: SRAM model, beat monitor and hand-computed expectations.
module tb_sram_mailbox_master;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic [8:0]  sram_address;
    logic        sram_clken;
    logic        sram_chipselect;
    logic        sram_write;
    logic [31:0] sram_readdata;
    logic [31:0] sram_writedata;
    logic [3:0]  sram_byteenable;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [6:0]  out_opcode;
    logic        out_last;
    logic        busy;
    logic [15:0] cmd_count;

    sram_mailbox_master #(
        .READ_LATENCY(1), .CMD_ADDR(0), .STATUS_ADDR(1), .PAYLOAD_BASE(2),
        .MAX_LEN(256), .POLL_GAP(16), .TIMEOUT(65535)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .sram_address(sram_address), .sram_clken(sram_clken),
        .sram_chipselect(sram_chipselect), .sram_write(sram_write),
        .sram_readdata(sram_readdata), .sram_writedata(sram_writedata),
        .sram_byteenable(sram_byteenable), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_opcode(out_opcode),
        .out_last(out_last), .busy(busy), .cmd_count(cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency SRAM with a host write port
    logic [31:0] mem [0:511];
    logic        hw_en;
    logic [8:0]  hw_addr;
    logic [31:0] hw_data;
    always @(posedge clk) begin
        if (sram_chipselect && !sram_write) sram_readdata <= mem[sram_address];
        if (sram_chipselect && sram_write)  mem[sram_address] <= sram_writedata;
        if (hw_en) mem[hw_addr] <= hw_data;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [32:0] beats [$];
    logic [6:0]  beat_op [$];
    int          rd0 [$];
    int          wr_cnt = 0;
    int          busy_seen = 0;
    int          hold_viol = 0;
    int          stall_seen = 0;
    logic        pv = 1'b0;
    logic        pr = 1'b0;
    logic        pl = 1'b0;
    logic [31:0] pd = '0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) begin
                beats.push_back({out_last, out_data});
                beat_op.push_back(out_opcode);
            end
            if (sram_chipselect && !sram_write && sram_address == 9'd0) rd0.push_back(cyc);
            if (sram_chipselect && sram_write) wr_cnt++;
            if (busy) busy_seen++;
            if (pv && !pr) begin
                stall_seen++;
                if (!(out_valid && out_data == pd && out_last == pl)) hold_viol++;
            end
        end
        pv = reset_n && out_valid;
        pr = out_ready;
        pd = out_data;
        pl = out_last;
    end

    // out_ready modes: 0 low, 1 high, 2 pattern 1,0,0,1, 3 high until one beat past ready_base
    int ready_mode = 0;
    int ready_base = 0;
    initial begin
        int pat;
        pat = 0;
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       out_ready = 1'b1;
                2:       out_ready = (pat % 4 == 0) || (pat % 4 == 3);
                3:       out_ready = (beats.size() <= ready_base);
                default: out_ready = 1'b0;
            endcase
            pat++;
        end
    end

    int errors = 0;
    int checks = 0;
    logic [31:0] pay [0:2];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic hw(input logic [8:0] a, input logic [31:0] d);
        @(posedge clk);
        #1;
        hw_en = 1'b1;
        hw_addr = a;
        hw_data = d;
        @(posedge clk);
        #1;
        hw_en = 1'b0;
    endtask

    task automatic wait_cmd(input logic [15:0] n, input string tag);
        int k;
        k = 0;
        while (cmd_count !== n && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check(tag, 128'(cmd_count), 128'(n));
    endtask

    task automatic check_beats(input int base, input string tag);
        logic [32:0] e;
        check({tag, "_nbeats"}, 128'(beats.size() - base), 128'(3));
        for (int i = 0; i < 3; i++) begin
            e = {(i == 2), pay[i]};
            check($sformatf("%s_beat%0d", tag, i), 128'(beats[base + i]), 128'(e));
            check($sformatf("%s_op%0d", tag, i), 128'(beat_op[base + i]), 128'(7'h05));
        end
    endtask

    function automatic logic [105:0] all_outs();
        return {sram_address, sram_clken, sram_chipselect, sram_write, sram_writedata,
                sram_byteenable, out_valid, out_data, out_opcode, out_last, busy, cmd_count};
    endfunction

    initial begin
        int base;
        int h0;
        int s0;
        int k;
        pay[0] = 32'hA1A1_0001;
        pay[1] = 32'hB2B2_0002;
        pay[2] = 32'hC3C3_0003;
        reset_n = 1'b0;
        enable  = 1'b0;
        hw_en   = 1'b0;
        hw_addr = '0;
        hw_data = '0;
        repeat (2) @(posedge clk);
        for (int a = 0; a < 5; a++) hw(9'(a), 32'h0);
        @(negedge clk);
        check("reset_outputs", 128'(all_outs()), 128'(0));

        // Idle polling with go=0
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        enable  = 1'b1;
        repeat (60) @(negedge clk);
        check("poll_count", 128'(rd0.size() >= 3), 128'(1));
        check("poll_period0", 128'(rd0[1] - rd0[0]), 128'(19));
        check("poll_period1", 128'(rd0[2] - rd0[1]), 128'(19));
        check("idle_no_writes", 128'(wr_cnt), 128'(0));
        check("idle_busy", 128'(busy_seen), 128'(0));
        check("idle_cmd_count", 128'(cmd_count), 128'(0));

        // Three-beat command, ready always high
        hw(9'd2, pay[0]);
        hw(9'd3, pay[1]);
        hw(9'd4, pay[2]);
        base = beats.size();
        ready_mode = 1;
        hw(9'd0, 32'h8500_0003);
        wait_cmd(16'd1, "cmd1_done");
        check_beats(base, "t2");
        check("t2_status", 128'(mem[1]), 128'(32'h8280_0003));
        check("t2_cmd_clear", 128'(mem[0]), 128'(0));
        check("t2_busy_seen", 128'(busy_seen > 0), 128'(1));
        check("t2_busy_after", 128'(busy), 128'(0));

        // Same command with out_ready toggling 1,0,0,1
        base = beats.size();
        h0 = hold_viol;
        s0 = stall_seen;
        ready_mode = 2;
        hw(9'd0, 32'h8500_0003);
        wait_cmd(16'd2, "cmd2_done");
        check_beats(base, "t3");
        check("t3_hold_stable", 128'(hold_viol - h0), 128'(0));
        check("t3_stalls_seen", 128'(stall_seen - s0 > 0), 128'(1));

        // Zero-length command
        ready_mode = 1;
        base = beats.size();
        hw(9'd0, 32'h8100_0000);
        wait_cmd(16'd3, "cmd3_done");
        check("t4_no_beats", 128'(beats.size() - base), 128'(0));
        check("t4_status", 128'(mem[1]), 128'(32'h8080_0000));
        check("t4_cmd_clear", 128'(mem[0]), 128'(0));

        // Over-length command
        base = beats.size();
        hw(9'd0, 32'h8100_0101);
        wait_cmd(16'd4, "cmd4_done");
        check("t5_no_beats", 128'(beats.size() - base), 128'(0));
        check("t5_status", 128'(mem[1]), 128'(32'hC080_0000));
        check("t5_cmd_clear", 128'(mem[0]), 128'(0));

        // Reset while beat 2 of 3 is pending
        base = beats.size();
        ready_base = base;
        ready_mode = 3;
        hw(9'd0, 32'h8500_0003);
        k = 0;
        while (!(beats.size() > base && out_valid === 1'b1) && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("t6_beat2_pending", 128'(out_valid), 128'(1));
        check("t6_beat2_data", 128'(out_data), 128'(pay[1]));
        reset_n = 1'b0;
        #1;
        check("t6_reset_outputs", 128'(all_outs()), 128'(0));
        check("t6_cmd_kept", 128'(mem[0]), 128'(32'h8500_0003));
        repeat (3) @(posedge clk);
        #1;
        base = beats.size();
        ready_mode = 1;
        reset_n = 1'b1;
        wait_cmd(16'd1, "t6_repoll_done");
        check_beats(base, "t6");
        check("t6_status", 128'(mem[1]), 128'(32'h8280_0003));
        check("t6_cmd_clear", 128'(mem[0]), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_mailbox_master.md
Name: sram_mailbox_master

Overview:
- FPGA-side master on the Computer_System `onchip_sram_s1` port.
- Polls a command word that the HPS writes into on-chip SRAM, then streams the command's payload words downstream over a valid/ready interface.
- Writes a completion status word back to SRAM and clears the command word, handing the mailbox back to the HPS.
- Sits between the `Computer_System` on-chip SRAM slave and the game/draw logic, clocked from `m10k_pll_outclk0_clk`.

Parameters:
- READ_LATENCY, 1, cycles from read issue to `sram_readdata` valid (1..3).
- CMD_ADDR, 0, word address of the command word.
- STATUS_ADDR, 1, word address of the status word.
- PAYLOAD_BASE, 2, word address of the first payload word.
- MAX_LEN, 256, maximum payload words; PAYLOAD_BASE+MAX_LEN <= 512.
- POLL_GAP, 16, idle cycles between polls that find go=0.
- TIMEOUT, 65535, stall cycles before abort (only with MBOX_TIMEOUT_EN).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  allow new polls
- sram_address  out  9  SRAM word address
- sram_clken  out  1  SRAM clock enable
- sram_chipselect  out  1  SRAM select
- sram_write  out  1  1=write, 0=read
- sram_readdata  in  32  SRAM read data
- sram_writedata  out  32  SRAM write data
- sram_byteenable  out  4  byte lanes
- out_valid  out  1  payload beat valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  32  payload word
- out_opcode  out  7  opcode of the current command
- out_last  out  1  final beat of the command
- busy  out  1  command in progress
- cmd_count  out  16  completed commands

Behaviour:
- Reset (async assert, sync release): every output is 0 and the FSM enters S_IDLE.
- SRAM access is one cycle: chipselect=1, clken=1, byteenable=4'hF. Between accesses chipselect, clken, write and byteenable are all 0.
- Read data is captured exactly READ_LATENCY cycles after the read is issued. A read-wait counter covers this; only one access is outstanding at a time.
- Command word format: [31] go, [30:24] opcode, [8:0] len.
- Status word format: [31] done=1, [30] err, [29:23] opcode, [22:9] 0, [8:0] beats delivered.
- FSM states and transitions:
  - S_IDLE: if enable, go to S_POLL_RD.
  - S_POLL_RD: read CMD_ADDR, then go to S_POLL_WAIT.
  - S_POLL_WAIT: after the latency, latch opcode and len.
    - go=0: go to S_GAP.
    - go=1, len > MAX_LEN: set err, go to S_STAT_WR.
    - go=1, len=0: go to S_STAT_WR with count 0 and no beats issued.
    - otherwise: go to S_PAY_RD with idx=0.
  - S_PAY_RD: read PAYLOAD_BASE+idx, then go to S_PAY_WAIT.
  - S_PAY_WAIT: after the latency, load `out_data`, set out_valid=1 and out_last=(idx==len-1), go to S_PUSH.
  - S_PUSH: hold out_valid, out_data and out_last stable until out_ready=1.
    - The beat is accepted in the cycle where out_valid && out_ready.
    - Next cycle out_valid=0 and idx increments.
    - If that beat had out_last=1, go to S_STAT_WR; otherwise go to S_PAY_RD.
  - S_STAT_WR: write the status word to STATUS_ADDR, then go to S_CLR_WR.
  - S_CLR_WR: write 32'h0 to CMD_ADDR, increment cmd_count (wraps 16'hFFFF->0), go to S_GAP.
  - S_GAP: wait POLL_GAP cycles, then go to S_POLL_RD if enable, else S_IDLE.
- Status is always written before the command word is cleared, so the HPS sees go=0 only after the status is valid.
- busy=1 from the go=1 capture through S_CLR_WR inclusive; 0 otherwise.
- out_opcode holds the latched opcode while busy; it is 0 after reset.
- enable is sampled only in S_IDLE and S_GAP. Deasserting it mid-command lets the command complete.
- An asynchronous reset mid-command aborts at once: no status write, the command word is left set, and the command is re-polled after reset.
- Beat throughput is 1 beat per (READ_LATENCY+2) cycles minimum. Payload reads are not pipelined.

Optional Feature:
- Macro: MBOX_TIMEOUT_EN.
- Defined:
  - A stall counter counts S_PUSH cycles with out_ready=0 and resets on each accepted beat.
  - When it reaches TIMEOUT: drop out_valid, set err=1, and go to S_STAT_WR.
  - The status word's beat count is the number of beats accepted so far.
- Undefined: S_PUSH waits indefinitely and the counter is not built.

Test Plan:
- enable=1, SRAM[0]=0 -> a read of address 0 repeats every POLL_GAP+READ_LATENCY+2 cycles; no writes, busy=0, cmd_count=0.
- SRAM[0]=0x8500_0003, SRAM[2..4]=A,B,C, out_ready=1 -> beats A,B,C with out_opcode=0x05 and out_last only on C; then SRAM[1]=0x8280_0003, SRAM[0]=0, cmd_count=1.
- Same command with out_ready toggling 1,0,0,1 -> each beat's data and last are held stable while out_ready=0; the sequence is exactly A,B,C with no duplicates.
- SRAM[0]=0x8100_0000 (len 0) -> no beats; SRAM[1]=0x8080_0000; SRAM[0]=0.
- SRAM[0]=0x8100_0101 (len 257) -> no beats; SRAM[1]=0xC080_0000 (err set).
- Reset pulsed during beat 2 of 3 -> all outputs 0 immediately; SRAM[0] is unchanged; after release the command is re-polled and all 3 beats are streamed again.
